// File: rtl/sram_ctrl_param_if.sv
// sram_ctrl_param_if: CPU-side request/response bundle for the SRAM controller
interface sram_ctrl_param_if #(
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 32,
  parameter int SRAM_DW = 64
);
  logic               rd_en;
  logic               wr_en;
  logic [ADDR_W-1:0]  addr;
  logic [DATA_W-1:0]  wdata;
  logic [SRAM_DW-1:0] rdata;
  logic               ready;
  logic               err;
  modport master (output rd_en, wr_en, addr, wdata, input rdata, ready, err);
  modport slave  (input rd_en, wr_en, addr, wdata, output rdata, ready, err);
endinterface

// File: rtl/sram_ctrl_param.sv
// sram_ctrl_param: MEM-stage controller for an async SRAM with wait states, range/alignment error and back-to-back requests
module sram_ctrl_param #(
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 32,
  parameter int SRAM_DW     = 64,
  parameter int SRAM_AW     = 17,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 5
) (
  input  logic               clk,
  input  logic               rst,
  sram_ctrl_param_if.slave   bus,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N
);
  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               wr_q, wr_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [SRAM_DW-1:0] data_q, data_d;
  logic [SRAM_DW-1:0] rdata_q, rdata_d;
  logic               err_q, err_d;
  logic [ADDR_W-1:0]  woff;
  logic               req, valid, drive;
  assign req   = bus.rd_en | bus.wr_en;
  assign woff  = (bus.addr - BASE) >> 2;
  assign valid = (bus.addr >= BASE) && ((woff >> SRAM_AW) == '0) && (bus.addr[1:0] == 2'b00);
  assign drive = (state_q == ACCESS) && wr_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: if (req) begin
        wr_d    = !bus.rd_en;
        err_d   = !valid;
        data_d  = SRAM_DW'(bus.wdata);
        cnt_d   = '0;
        state_d = valid ? ACCESS : DONE;
        addr_d  = valid ? SRAM_AW'(woff) : addr_q;
        rdata_d = (!valid && bus.rd_en) ? '0 : rdata_q;
      end
      ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WAIT_CYCLES - 1)) begin
          state_d = DONE;
          rdata_d = wr_q ? rdata_q : SRAM_DQ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  assign SRAM_DQ   = drive ? data_q : 'z;
  assign SRAM_ADDR = addr_q;
  assign SRAM_WE_N = !drive;
  assign SRAM_OE_N = !((state_q == ACCESS) && !wr_q);
  assign bus.rdata = rdata_q;
  assign bus.err   = err_q;
  assign bus.ready = ((state_q == IDLE) && !req) || (state_q == DONE);
endmodule

// File: tb/tb_sram_ctrl_param.sv
// tb_sram_ctrl_param: directed + random requests against a word-level memory model of the SRAM controller
module tb_sram_ctrl_param;
  localparam int W = 5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  sram_ctrl_param_if #(.ADDR_W(19), .DATA_W(32), .SRAM_DW(64)) bus();
  wire  [63:0] dq;
  logic [16:0] sa;
  logic        we_n, oe_n;
  sram_ctrl_param #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .SRAM_DQ(dq), .SRAM_ADDR(sa), .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n)
  );
  function automatic logic [63:0] seed(int i);
    return (i == 2) ? 64'hDEADBEEF_01234567 : {32'(i) * 32'h9E3779B9, 32'hC0DE0000 + 32'(i)};
  endfunction
  logic [63:0] mem [256];
  logic [63:0] exp_mem [256];
  logic [63:0] exp_rdata;
  assign dq = !oe_n ? mem[sa[7:0]] : 'z;
  always @(posedge clk) begin
    if (rst) for (int i = 0; i < 256; i++) mem[i] <= seed(i);
    else if (!we_n) mem[sa[7:0]] <= dq;
  end
  int we_tot = 0, oe_tot = 0, both_tot = 0, dq_bad = 0;
  logic [16:0] strobe_addr = '0;
  logic [63:0] dq_exp = '0;
  always @(negedge clk) begin
    if (!we_n) begin we_tot++; strobe_addr = sa; if (dq !== dq_exp) dq_bad++; end
    if (!oe_n) begin oe_tot++; strobe_addr = sa; end
    if (!we_n && !oe_n) both_tot++;
  end
  int n_cmp = 0, n_fail = 0;
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic reset_model();
    for (int i = 0; i < 256; i++) exp_mem[i] = seed(i);
    exp_rdata = '0;
  endtask
  task automatic req(input bit rd, input bit wr, input logic [18:0] a, input logic [31:0] wd, input bit keep);
    int word, cyc, we0, oe0, db0, bt0;
    bit valid;
    valid = (a >= 19'd1024) && (a[1:0] == 2'b00) && (((int'(a) - 1024) / 4) < (1 << 17));
    word  = (int'(a) - 1024) / 4;
    @(posedge clk); #1;
    bus.rd_en = rd; bus.wr_en = wr; bus.addr = a; bus.wdata = wd;
    dq_exp = {32'b0, wd};
    we0 = we_tot; oe0 = oe_tot; db0 = dq_bad; bt0 = both_tot;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!bus.ready && cyc < 40);
    #1;
    chk("latency", 64'(cyc), valid ? 64'(W + 2) : 64'd2);
    chk("err", bus.err, {63'b0, !valid});
    if (valid && !rd) exp_mem[word] = {32'b0, wd};
    if (rd) exp_rdata = valid ? exp_mem[word] : 64'b0;
    chk("rdata", bus.rdata, exp_rdata);
    chk("we_cycles", 64'(we_tot - we0), (valid && !rd) ? 64'(W) : 64'd0);
    chk("oe_cycles", 64'(oe_tot - oe0), (valid && rd) ? 64'(W) : 64'd0);
    if (valid) chk("sram_addr", 64'(strobe_addr), 64'(word));
    chk("dq_write", 64'(dq_bad - db0), 64'd0);
    chk("contention", 64'(both_tot - bt0), 64'd0);
    if (!keep) begin
      @(posedge clk); #1;
      bus.rd_en = 1'b0; bus.wr_en = 1'b0;
      @(negedge clk);
      chk("ready_idle", {63'b0, bus.ready}, 64'd1);
    end
  endtask
  initial begin
    bit rd, wr, keep;
    int w;
    logic [18:0] a;
    bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.addr = '0; bus.wdata = '0;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {63'b0, bus.ready}, 64'd1);
    chk("rst_err", {63'b0, bus.err}, 64'd0);
    chk("rst_rdata", bus.rdata, 64'd0);
    chk("rst_we_n", {63'b0, we_n}, 64'd1);
    chk("rst_oe_n", {63'b0, oe_n}, 64'd1);
    chk("rst_sram_addr", 64'(sa), 64'd0);
    @(negedge clk); rst = 1'b0;
    req(1'b1, 1'b0, 19'd1032, 32'h0, 1'b0);
    chk("t1_rdata", bus.rdata, 64'hDEADBEEF_01234567);
    req(1'b0, 1'b1, 19'd1024, 32'hA5A5_0F0F, 1'b0);
    req(1'b1, 1'b1, 19'd1028, 32'hFFFF_FFFF, 1'b0);
    req(1'b1, 1'b0, 19'd1000, 32'h0, 1'b0);
    req(1'b1, 1'b0, 19'd1026, 32'h0, 1'b0);
    req(1'b0, 1'b1, 19'd1001, 32'h1234_5678, 1'b0);
    req(1'b1, 1'b0, 19'd1024, 32'h0, 1'b1);
    req(1'b1, 1'b0, 19'd1028, 32'h0, 1'b0);
    @(posedge clk); #1;
    bus.wr_en = 1'b1; bus.rd_en = 1'b0; bus.addr = 19'd1064; bus.wdata = 32'h5555_AAAA;
    dq_exp = 64'h5555_AAAA;
    repeat (3) @(posedge clk);
    #2;
    chk("mid_write_we_n", {63'b0, we_n}, 64'd0);
    rst = 1'b1; bus.wr_en = 1'b0;
    #1;
    chk("abort_we_n", {63'b0, we_n}, 64'd1);
    chk("abort_oe_n", {63'b0, oe_n}, 64'd1);
    chk("abort_ready", {63'b0, bus.ready}, 64'd1);
    chk("abort_sram_addr", 64'(sa), 64'd0);
    chk("abort_rdata", bus.rdata, 64'd0);
    reset_model();
    @(posedge clk); @(negedge clk); rst = 1'b0;
    req(1'b1, 1'b0, 19'd1032, 32'h0, 1'b0);
    for (int n = 0; n < 30; n++) begin
      rd   = 1'($urandom_range(0, 1));
      wr   = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      w    = $urandom_range(0, 63);
      a    = 19'(1024 + 4 * w);
      if ($urandom_range(0, 5) == 0)
        a = $urandom_range(0, 1) ? 19'($urandom_range(0, 1023)) : 19'(1024 + 4 * w + $urandom_range(1, 3));
      keep = (n != 29) && ($urandom_range(0, 3) == 0);
      req(rd, wr, a, $urandom, keep);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
